// File: rtl/prefix_pkg.sv
// Shared prefix-network types and helpers, used by the 6-bit prefix adder and by its subtract companion.
package prefix_pkg;

    localparam int unsigned DATA_W = 6;
    localparam int unsigned SUM_W  = 7;

    typedef struct packed {
        logic h;
        logic g;
        logic p;
    } hgp_t;

    // Stage boundary after the span-2 level. Group propagate of bits 0/1 is dropped:
    // once carry-in is folded into bit 0 those spans are fully resolved.
    typedef struct packed {
        logic [SUM_W-1:0] h;
        logic [SUM_W-1:0] g;
        logic [SUM_W-1:2] p;
    } gp_stage_t;

    localparam int unsigned STAGE_W = $bits(gp_stage_t);

    function automatic hgp_t bit_gen(input logic x, input logic y);
        hgp_t r;
        r.h = x ^ y;
        r.g = x & y;
        r.p = x | y;
        return r;
    endfunction

    // Returns {G, P} of the span (i over j)
    function automatic logic [1:0] gp_combine(input logic gi, input logic pi,
                                              input logic gj, input logic pj);
        return {gi | (pi & gj), pi & pj};
    endfunction

endpackage

// File: rtl/prefix_sub_core.sv
// Combinational 7-bit prefix subtract d = s + ~{0,a} + 1, split at the stage1/stage2 boundary.
module prefix_sub_core
    import prefix_pkg::*;
(
    input  logic [SUM_W-1:0]   s,
    input  logic [DATA_W-1:0]  a,
    output logic [STAGE_W-1:0] stage1_gp_out,
    input  logic [STAGE_W-1:0] stage2_gp_in,
    output logic [SUM_W-1:0]   d,
    output logic               borrow
);

    logic [SUM_W-1:0] w_b;
    logic [SUM_W-1:0] w_h;
    logic [SUM_W-1:0] w_g;
    logic [SUM_W-1:0] w_p;
    hgp_t             w_bit;
    logic [SUM_W-1:0] w_l1g;
    logic [SUM_W-1:2] w_l1p;
    logic [1:0]       w_c1;
    gp_stage_t        w_s1;
    gp_stage_t        w_s2;
    logic [SUM_W-1:0] w_l2g;
    logic [SUM_W-1:4] w_l2p;
    logic [1:0]       w_c2;
    logic [SUM_W-1:0] w_l3g;

    assign w_b = ~{1'b0, a};

    always_comb begin
        w_h   = '0;
        w_g   = '0;
        w_p   = '0;
        w_bit = '0;
        for (int unsigned i = 0; i < SUM_W; i++) begin
            w_bit  = bit_gen(s[i], w_b[i]);
            w_h[i] = w_bit.h;
            w_g[i] = w_bit.g;
            w_p[i] = w_bit.p;
        end
        // carry-in of 1 folded into bit 0
        w_g[0] = w_g[0] | w_p[0];
    end

    always_comb begin
        w_l1g    = w_g;
        w_l1p    = '0;
        w_c1     = '0;
        w_l1g[1] = w_g[1] | (w_p[1] & w_g[0]);
        for (int unsigned i = 2; i < SUM_W; i++) begin
            w_c1     = gp_combine(w_g[i], w_p[i], w_g[i-1], w_p[i-1]);
            w_l1g[i] = w_c1[1];
            w_l1p[i] = w_c1[0];
        end
    end

    always_comb begin
        w_s1   = '0;
        w_s1.h = w_h;
        w_s1.g = w_l1g;
        w_s1.p = w_l1p;
    end

    assign stage1_gp_out = w_s1;
    assign w_s2          = gp_stage_t'(stage2_gp_in);

    always_comb begin
        w_l2g = w_s2.g;
        w_l2p = '0;
        w_c2  = '0;
        for (int unsigned i = 2; i < 4; i++) begin
            w_l2g[i] = w_s2.g[i] | (w_s2.p[i] & w_s2.g[i-2]);
        end
        for (int unsigned i = 4; i < SUM_W; i++) begin
            w_c2     = gp_combine(w_s2.g[i], w_s2.p[i], w_s2.g[i-2], w_s2.p[i-2]);
            w_l2g[i] = w_c2[1];
            w_l2p[i] = w_c2[0];
        end
    end

    always_comb begin
        w_l3g = w_l2g;
        for (int unsigned i = 4; i < SUM_W; i++) begin
            w_l3g[i] = w_l2g[i] | (w_l2p[i] & w_l2g[i-4]);
        end
    end

    always_comb begin
        d    = '0;
        d[0] = w_s2.h[0] ^ 1'b1;
        for (int unsigned i = 1; i < SUM_W; i++) begin
            d[i] = w_s2.h[i] ^ w_l3g[i-1];
        end
    end

    assign borrow = ~w_l3g[SUM_W-1];

endmodule

// File: rtl/prefix_sub_recover.sv
// Two-stage pipelined operand recovery y = s - a with valid/ready handshakes,
// invalid-recovery flag and saturating error counter.
module prefix_sub_recover
    import prefix_pkg::*;
#(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SUM_W-1:0]     in_s,
    input  logic [DATA_W-1:0]    in_a,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_y,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic                 r_v1;
    logic                 r_v2;
    logic [STAGE_W-1:0]   r_stage1;
    logic [DATA_W-1:0]    r_y;
    logic                 r_err;
    logic [ERR_CNT_W-1:0] r_err_count;

    logic                 w_adv1;
    logic                 w_adv2;
    logic [STAGE_W-1:0]   w_stage1;
    logic [SUM_W-1:0]     w_d;
    logic                 w_borrow;

    prefix_sub_core u_core (
        .s             (in_s),
        .a             (in_a),
        .stage1_gp_out (w_stage1),
        .stage2_gp_in  (r_stage1),
        .d             (w_d),
        .borrow        (w_borrow)
    );

    assign w_adv2   = ~r_v2 | out_ready;
    assign w_adv1   = ~r_v1 | w_adv2;
    assign in_ready = rst_n & w_adv1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_stage1 <= '0;
            r_y      <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_adv1) begin
                r_v1 <= in_valid;
                if (in_valid) begin
                    r_stage1 <= w_stage1;
                end
            end
            if (w_adv2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_y   <= w_d[DATA_W-1:0];
                    r_err <= w_borrow | w_d[SUM_W-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (r_v2 && out_ready && r_err && (r_err_count != '1)) begin
            r_err_count <= r_err_count + ERR_CNT_W'(1);
        end
    end

    assign out_valid = r_v2;
    assign out_y     = r_y;
    assign out_err   = r_err;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_prefix_sub_recover.sv
// Directed and randomized checks of prefix_sub_recover against a plain-arithmetic s - a model.
module tb_prefix_sub_recover;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_s;
    logic [5:0] in_a;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_y;
    logic       out_err;
    logic [7:0] err_count;

    logic       in_ready_s;
    logic       out_valid_s;
    logic [5:0] out_y_s;
    logic       out_err_s;
    logic [1:0] err_count_s;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [6:0] exp_q[$];
    int         model_cnt   = 0;
    int         model_cnt_s = 0;
    int         n_delivered = 0;
    bit         last_acc    = 1'b0;
    bit         prev_stall  = 1'b0;
    logic [5:0] prev_y;
    logic       prev_err;

    always #5 clk = ~clk;

    prefix_sub_recover #(.ERR_CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_s      (in_s),
        .in_a      (in_a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_err   (out_err),
        .err_count (err_count)
    );

    prefix_sub_recover #(.ERR_CNT_W(2)) dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .in_s      (in_s),
        .in_a      (in_a),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .out_y     (out_y_s),
        .out_err   (out_err_s),
        .err_count (err_count_s)
    );

    function automatic logic [6:0] ref_sub(input int s, input int a);
        int         diff;
        logic       e;
        logic [5:0] y;
        diff = s - a;
        e    = (diff < 0) || (diff > 63);
        y    = 6'((diff + 128) % 64);
        return {e, y};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cycle();
        logic [6:0] e;
        @(negedge clk);
        last_acc = 1'b0;
        if (rst_n) begin
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_y", 32'(out_y), 32'(prev_y));
                check("hold_err", 32'(out_err), 32'(prev_err));
            end
            if (out_valid && out_ready) begin
                check("spurious", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("y", 32'(out_y), 32'(e[5:0]));
                    check("err", 32'(out_err), 32'(e[6]));
                    n_delivered++;
                    if (e[6]) begin
                        if (model_cnt < 255) model_cnt++;
                        if (model_cnt_s < 3) model_cnt_s++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_sub(int'(in_s), int'(in_a)));
                last_acc = 1'b1;
            end
            prev_stall = out_valid && !out_ready;
            prev_y     = out_y;
            prev_err   = out_err;
        end else begin
            prev_stall = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int s, input int a);
        in_valid = 1'b1;
        in_s     = 7'(s);
        in_a     = 6'(a);
        cycle();
        check("accept", 32'(last_acc), 1);
    endtask

    task automatic drain();
        int budget;
        budget   = 50;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && budget > 0) begin
            cycle();
            budget--;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        int idx;
        int budget;
        int d0;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_s      = '0;
        in_a      = '0;
        out_ready = 1'b0;

        // reset state
        repeat (2) cycle();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_y", 32'(out_y), 0);
        check("rst_out_err", 32'(out_err), 0);
        check("rst_err_count", 32'(err_count), 0);
        check("rst_err_count_s", 32'(err_count_s), 0);
        rst_n = 1'b1;
        #1;
        check("in_ready_after_rst", 32'(in_ready), 1);

        // test 1: latency
        out_ready = 1'b1;
        put(100, 37);
        in_valid = 1'b0;
        check("lat_cycle1_valid", 32'(out_valid), 0);
        cycle();
        check("lat_cycle2_valid", 32'(out_valid), 1);
        check("lat_y", 32'(out_y), 63);
        check("lat_err", 32'(out_err), 0);
        drain();

        // test 2/3: boundary values and error cases
        put(126, 63);
        put(0, 0);
        put(0, 1);
        put(100, 30);
        drain();
        check("err_count_2", 32'(err_count), 2);
        check("err_count_s_2", 32'(err_count_s), 2);

        // saturation of the 2-bit counter
        put(0, 5);
        put(10, 20);
        put(3, 63);
        drain();
        check("err_count_5", 32'(err_count), 5);
        check("err_count_s_sat", 32'(err_count_s), 3);

        // test 4: backpressure
        out_ready = 1'b0;
        put(20, 5);
        put(40, 10);
        check("bp_in_ready", 32'(in_ready), 0);
        check("bp_out_valid", 32'(out_valid), 1);
        check("bp_y", 32'(out_y), 15);
        in_valid = 1'b1;
        in_s     = 7'd60;
        in_a     = 6'd15;
        cycle();
        check("bp_no_accept", 32'(last_acc), 0);
        cycle();
        check("bp_y_held", 32'(out_y), 15);
        d0 = n_delivered;
        out_ready = 1'b1;
        cycle();
        check("bp_accept3", 32'(last_acc), 1);
        drain();
        check("bp_delivered", n_delivered - d0, 3);

        // test 5: all (s,a) pairs with random handshakes
        idx    = 0;
        budget = 60000;
        while (idx < 8192 && budget > 0) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_s      = 7'(idx >> 6);
            in_a      = 6'(idx & 63);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (last_acc) idx++;
            budget--;
        end
        check("sweep_issued", idx, 8192);
        drain();
        check("sweep_err_count", 32'(err_count), model_cnt);
        check("sweep_err_count_s", 32'(err_count_s), model_cnt_s);

        // test 6: reset with two transactions in flight
        out_ready = 1'b0;
        put(5, 1);
        put(9, 2);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        cycle();
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_in_ready", 32'(in_ready), 0);
        check("midrst_err_count", 32'(err_count), 0);
        check("midrst_err_count_s", 32'(err_count_s), 0);
        exp_q.delete();
        model_cnt   = 0;
        model_cnt_s = 0;
        cycle();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        d0        = n_delivered;
        repeat (6) cycle();
        check("no_stale_count", n_delivered - d0, 0);
        check("no_stale_valid", 32'(out_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/prefix_sub_recover.md
Name: prefix_sub_recover

Overview:
- Inverse companion of the 6-bit parallel-prefix adder: takes a 7-bit sum `s` and one 6-bit operand `a`, and recovers the other operand `y = s - a`.
- Subtraction uses the same generate/propagate/half-sum prefix structure, computed as `s + ~a + 1` over 7 bits.
- The block is a 2-stage pipeline with valid/ready handshakes on both sides.
- It flags results that cannot be a 6-bit operand and keeps a saturating error count.
- It sits after the adder, or after a checksum path, to verify or decode sums.

Parameters:
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  input transaction valid.
- in_ready  output  1  block accepts input this cycle.
- in_s  input  7  sum operand, unsigned 0..127.
- in_a  input  6  known operand, unsigned 0..63.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_y  output  6  recovered operand, `d[5:0]`.
- out_err  output  1  recovery invalid: `s < a` or `d > 63`.
- err_count  output  ERR_CNT_W  saturating count of delivered results with `out_err` = 1.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is synchronous and active-low.
- Reset values: `out_valid`=0, `out_y`=0, `out_err`=0, `err_count`=0, and both internal stage-valid bits are 0.
  - `in_ready` is 0 in any cycle where `rst_n`=0.
  - Reset mid-operation discards all in-flight transactions; nothing is emitted for them.
- Arithmetic:
  - `b = {1'b0, ~in_a} | 7'b1000000`, i.e. `~{1'b0, in_a}` over 7 bits, with carry-in 1.
  - `d7 = in_s + b + 1` computed in 8 bits. `borrow = ~carry_out`, i.e. `in_s < in_a`. `d = d7[6:0]`.
  - `out_y = d[5:0]`.
  - `out_err = borrow | d[6]`.
  - On underflow, `out_y` is the two's-complement wrap; e.g. `s=0, a=1` gives `out_y`=63.
- Stage 1 (registered on accept):
  - Per-bit `h`/`g`/`p` for 7 bits, with carry-in folded into bit 0 as `g0' = g0 | p0`.
  - First prefix level: pairwise group G/P spans 2.
- Stage 2 (registered): remaining prefix levels (spans 4 and 7), difference bits `h[i] ^ Gc[i-1]`, carry-out, and `out_err`.
- Latency: exactly 2 cycles from accept (`in_valid & in_ready`) to `out_valid`=1 when there is no backpressure. Throughput is 1 per cycle.
- Handshake:
  - `adv2 = ~v2 | out_ready`.
  - `adv1 = ~v1 | adv2`.
  - `in_ready = rst_n & adv1` (combinational).
  - Stage 2 loads from stage 1 when `adv2`. Its valid becomes `v1`.
  - Stage 1 loads when `adv1`. Its valid becomes `in_valid`.
  - `out_valid = v2`. While `out_valid=1 & out_ready=0`, `out_y` and `out_err` hold stable.
  - Data registers load only when their stage advances. When a bubble is loaded, the valid bit clears and the data content is don't-care.
- Full pipeline: when both stages are valid and `out_ready`=0, `in_ready`=0 and no input is lost.
- Simultaneous accept and deliver in the same cycle is legal and keeps full throughput.
- `err_count`: increments by 1 on each cycle with `out_valid & out_ready & out_err`, and saturates at `2^ERR_CNT_W - 1`. It resets only via `rst_n`.
- No combinational path from `in_*` to `out_*`.

Decomposition:
- Shared package (`prefix_pkg`) holds:
  - `localparam DATA_W = 6`, `SUM_W = 7`.
  - A typedef for the per-bit `{h,g,p}` struct.
  - Functions: prefix combine `(Gi | Pi&Gj, Pi&Pj)` and the per-bit generate.
  - The same package serves the adder.
- One natural sub-module: `prefix_sub_core`, a purely combinational 7-bit prefix subtract with inputs `s`, `a` and outputs `d`, `borrow`. The top instantiates its logic split across the two pipeline registers.
  - Alternatively the core exposes its stage boundary as ports: `stage1_gp_out` / `stage2_gp_in`.
- The top holds handshake, valid bits, and `err_count`.

Test Plan:
1. Reset, then `in_s=100, in_a=37`, `out_ready`=1 -> 2 cycles later `out_valid`=1, `out_y`=63, `out_err`=0.
2. `in_s=126, in_a=63` -> `out_y`=63, `out_err`=0. `in_s=0, in_a=0` -> `out_y`=0, `out_err`=0.
3. `in_s=0, in_a=1` -> `out_y`=63, `out_err`=1. `in_s=100, in_a=30` -> `d`=70, `out_y`=6, `out_err`=1. `err_count`=2.
4. Backpressure: stream `(20,5)`, `(40,10)`, `(60,15)` back-to-back with `out_ready`=0.
   - `in_ready` drops after 2 accepts; `out_y`=15 is held stable.
   - Raise `out_ready` -> outputs 15, 30, 45 in order, none lost or duplicated.
5. Exhaustive sweep of all 8192 `(s,a)` pairs, random `in_valid`/`out_ready` -> every result matches the reference `s - a` model and error rule, in order.
6. Reset mid-stream with 2 transactions in flight -> next cycle `out_valid`=0, `in_ready`=0 during reset, `err_count`=0, and no stale result appears afterwards. Saturation check: with ERR_CNT_W=2, 5 error results -> `err_count`=3.
